// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_cntrl Tx FIFO among NUM_REQ byte streams.
// Define UART_TX_ARB_PRIO_EN for fixed priority (lowest valid index wins).
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4,
    parameter int GW        = $clog2(NUM_REQ)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 fifo_wren,
    output logic [7:0]           fifo_wdata,
    input  logic                 data_fulltx,
    input  logic                 data_emptytx,
    input  logic                 busy_tx,
    output logic                 start_tx,
    output logic [GW-1:0]        grant_id,
    output logic                 active
);

    typedef enum logic [1:0] {IDLE, ARB, XFER, DRAIN} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [7:0]    burst_cnt;
    logic [GW-1:0] pick;
    logic          pick_ok;
    logic          xfer;
    logic          any_valid;
    logic          done;

    assign xfer      = (state == XFER);
    assign any_valid = |req_valid;

    // Winner selection for the next ARB cycle
    always_comb begin
        pick    = last_grant;
        pick_ok = 1'b0;
`ifdef UART_TX_ARB_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick    = GW'(i);
                pick_ok = 1'b1;
            end
        end
`else
        // Descending scan so the index right after last_grant wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                pick    = GW'((int'(last_grant) + k) % NUM_REQ);
                pick_ok = 1'b1;
            end
        end
`endif
    end

    // Zero-latency byte path from the granted requester into the FIFO
    always_comb begin
        req_ready  = '0;
        fifo_wren  = 1'b0;
        fifo_wdata = 8'h00;
        if (xfer) begin
            req_ready[grant_id] = ~data_fulltx;
            fifo_wren  = req_valid[grant_id] & ~data_fulltx;
            fifo_wdata = req_data[int'(grant_id)*8 +: 8];
        end
    end

    assign done = fifo_wren &
                  (req_last[grant_id] | ((burst_cnt + 8'd1) == 8'(BURST_MAX)));

    // Arbitration FSM; start_tx is held through the whole busy period.
    // An ARB entered with no valid requester falls through to DRAIN.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            start_tx   <= 1'b0;
            grant_id   <= '0;
            active     <= 1'b0;
            last_grant <= GW'(NUM_REQ - 1);
            burst_cnt  <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    start_tx <= 1'b0;
                    if (any_valid) begin
                        state  <= ARB;
                        active <= 1'b1;
                    end
                end
                ARB: begin
                    if (pick_ok) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        burst_cnt  <= 8'd0;
                        state      <= XFER;
                    end else begin
                        state <= DRAIN;
                    end
                end
                XFER: begin
                    if (fifo_wren) begin
                        burst_cnt <= burst_cnt + 8'd1;
                        start_tx  <= 1'b1;
                        if (done)
                            state <= any_valid ? ARB : DRAIN;
                    end
                end
                DRAIN: begin
                    if (any_valid) begin
                        state <= ARB;
                    end else if (data_emptytx && !busy_tx) begin
                        state    <= IDLE;
                        start_tx <= 1'b0;
                        active   <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
